// File: rtl/sid_bus_slave.sv
// SID register write-bus responder: synchronizes the host strobe,
// commits one byte per rising edge into voice/filter banks, emits gate events.
module sid_bus_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_VOICES  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_wr,
    input  logic [1:0]              bus_voice,
    input  logic [2:0]              bus_addr,
    input  logic [7:0]              bus_data,
    output logic [16*NUM_VOICES-1:0] freq_o,
    output logic [12*NUM_VOICES-1:0] pw_o,
    output logic [8*NUM_VOICES-1:0]  atk_dcy_o,
    output logic [8*NUM_VOICES-1:0]  sus_rel_o,
    output logic [8*NUM_VOICES-1:0]  wav_o,
    output logic [15:0]             fc_o,
    output logic [7:0]              res_filt_o,
    output logic [7:0]              mode_vol_o,
    output logic [NUM_VOICES-1:0]   gate_on_o,
    output logic [NUM_VOICES-1:0]   gate_off_o,
    output logic                    wr_ack_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   commit;

    logic [NUM_VOICES-1:0][15:0] freq_q, freq_d;
    logic [NUM_VOICES-1:0][11:0] pw_q, pw_d;
    logic [NUM_VOICES-1:0][7:0]  ad_q, ad_d;
    logic [NUM_VOICES-1:0][7:0]  sr_q, sr_d;
    logic [NUM_VOICES-1:0][7:0]  wav_q, wav_d;
    logic [15:0]                 fc_q, fc_d;
    logic [7:0]                  res_q, res_d;
    logic [7:0]                  mv_q, mv_d;
    logic                        ack_q, ack_d;
    logic [NUM_VOICES-1:0]       gon_q, gon_d;
    logic [NUM_VOICES-1:0]       goff_q, goff_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus_wr};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Bus fields are host-held stable around the strobe, so sample them raw.
    assign commit = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        freq_d = freq_q;
        pw_d   = pw_q;
        ad_d   = ad_q;
        sr_d   = sr_q;
        wav_d  = wav_q;
        fc_d   = fc_q;
        res_d  = res_q;
        mv_d   = mv_q;
        ack_d  = 1'b0;
        gon_d  = '0;
        goff_d = '0;
        if (commit) begin
            ack_d = 1'b1;
            if (bus_voice == 2'd3) begin
                case (bus_addr)
                    3'd0:    fc_d[7:0]  = bus_data;
                    3'd1:    fc_d[15:8] = bus_data;
                    3'd2:    res_d      = bus_data;
                    3'd3:    mv_d       = bus_data;
                    default: ;
                endcase
            end else begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (bus_voice == 2'(v)) begin
                        case (bus_addr)
                            3'd0: freq_d[v][7:0]  = bus_data;
                            3'd1: freq_d[v][15:8] = bus_data;
                            3'd2: pw_d[v][7:0]    = bus_data;
                            3'd3: pw_d[v][11:8]   = bus_data[3:0];
                            3'd4: ad_d[v]         = bus_data;
                            3'd5: sr_d[v]         = bus_data;
                            3'd6: begin
                                wav_d[v]  = bus_data;
                                gon_d[v]  = bus_data[0] & ~wav_q[v][0];
                                goff_d[v] = ~bus_data[0] & wav_q[v][0];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_q <= '0;
            pw_q   <= '0;
            ad_q   <= '0;
            sr_q   <= '0;
            wav_q  <= '0;
            fc_q   <= '0;
            res_q  <= '0;
            mv_q   <= '0;
            ack_q  <= 1'b0;
            gon_q  <= '0;
            goff_q <= '0;
        end else begin
            freq_q <= freq_d;
            pw_q   <= pw_d;
            ad_q   <= ad_d;
            sr_q   <= sr_d;
            wav_q  <= wav_d;
            fc_q   <= fc_d;
            res_q  <= res_d;
            mv_q   <= mv_d;
            ack_q  <= ack_d;
            gon_q  <= gon_d;
            goff_q <= goff_d;
        end
    end

    assign freq_o     = freq_q;
    assign pw_o       = pw_q;
    assign atk_dcy_o  = ad_q;
    assign sus_rel_o  = sr_q;
    assign wav_o      = wav_q;
    assign fc_o       = fc_q;
    assign res_filt_o = res_q;
    assign mode_vol_o = mv_q;
    assign wr_ack_o   = ack_q;
    assign gate_on_o  = gon_q;
    assign gate_off_o = goff_q;

endmodule
